afe_l2_rdaddrgen: RTL and testbench

AFE_L2_RDADDRGEN -- requirements
Module: afe_l2_rdaddrgen

---
 rtl/afe_l2_rdaddrgen.sv | 78 +++++++
 tb/tb_afe_l2_rdaddrgen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/afe_l2_rdaddrgen.sv
// afe_l2_rdaddrgen: circular-buffer read address generator that trails an L2 writer and flags overruns.
module afe_l2_rdaddrgen #(
  parameter int AWIDTH     = 18,
  parameter int TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [AWIDTH-1:0]     cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_clr_i,
  input  logic [TRANS_SIZE-1:0] wr_ptr_i,
  input  logic                  wr_wrap_i,
  output logic                  rd_req_o,
  output logic [AWIDTH-1:0]     rd_addr_o,
  input  logic                  rd_gnt_i,
  output logic [TRANS_SIZE-1:0] rd_ptr_o,
  output logic [TRANS_SIZE:0]   bytes_avail_o,
  output logic                  cfg_en_o,
  output logic                  overflow_o,
  output logic                  event_o
);
  typedef enum logic [1:0] {IDLE, WAIT, REQ, OVF} state_e;
  state_e state_q;
  logic [TRANS_SIZE-1:0] rd_ptr_q, rd_ptr_d, incr;
  logic [TRANS_SIZE:0] sum, avail, avail_post;
  logic rd_ph_q, rd_ph_d, wr_ph_q, wr_ph_d, ovf_q, event_q, gnt, rd_wrap, ovf_det;

  // Equal pointers with differing phases read as a full buffer, not as an overrun.
  function automatic logic [TRANS_SIZE:0] avail_f(input logic [TRANS_SIZE-1:0] rp, wp, sz, input logic same);
    return same ? {1'b0, wp} - {1'b0, rp} : {1'b0, sz} - {1'b0, rp} + {1'b0, wp};
  endfunction

  always_comb begin
    incr = cfg_datasize_i == 2'b00 ? TRANS_SIZE'(1) : cfg_datasize_i == 2'b01 ? TRANS_SIZE'(2) : TRANS_SIZE'(4);
    gnt = state_q == REQ && rd_gnt_i;
    sum = {1'b0, rd_ptr_q} + {1'b0, incr};
    rd_wrap = gnt && sum >= {1'b0, cfg_size_i};
    rd_ptr_d = rd_wrap ? '0 : gnt ? sum[TRANS_SIZE-1:0] : rd_ptr_q;
    rd_ph_d = rd_ph_q ^ rd_wrap;
    wr_ph_d = wr_ph_q ^ wr_wrap_i;
    avail = avail_f(rd_ptr_q, wr_ptr_i, cfg_size_i, rd_ph_q == wr_ph_q);
    avail_post = avail_f(rd_ptr_d, wr_ptr_i, cfg_size_i, rd_ph_d == wr_ph_d);
    ovf_det = (state_q == WAIT || state_q == REQ) && rd_ph_q != wr_ph_q && wr_ptr_i > rd_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_clr_i) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      rd_ph_q  <= 1'b0;
      wr_ph_q  <= 1'b0;
      ovf_q    <= 1'b0;
      event_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      state_q <= cfg_en_i ? WAIT : IDLE;
      event_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      rd_ph_q  <= rd_ph_d;
      wr_ph_q  <= wr_ph_d;
      event_q  <= rd_wrap;
      ovf_q    <= ovf_q | ovf_det;
      state_q  <= ovf_det ? OVF :
                  state_q == WAIT ? (avail >= {1'b0, incr} ? REQ : WAIT) :
                  (gnt && avail_post < {1'b0, incr}) ? WAIT : state_q;
    end
  end

  assign rd_req_o      = state_q == REQ;
  assign cfg_en_o      = state_q == WAIT || state_q == REQ;
  assign rd_addr_o     = cfg_startaddr_i + AWIDTH'(rd_ptr_q);
  assign rd_ptr_o      = rd_ptr_q;
  assign bytes_avail_o = avail;
  assign overflow_o    = ovf_q;
  assign event_o       = event_q;
endmodule

// File: tb/tb_afe_l2_rdaddrgen.sv
// tb_afe_l2_rdaddrgen: directed bench with a byte-count reference model checked every cycle.
module tb_afe_l2_rdaddrgen;
  logic clk = 1'b0, rst = 1'b1;
  logic [17:0] start = 18'h100;
  logic [15:0] size = 16'd16, wr_ptr = '0;
  logic [1:0] ds = 2'b10;
  logic en = 1'b0, clr = 1'b0, wrap = 1'b0, gnt = 1'b0;
  logic rd_req, cfg_en, ovf, ev;
  logic [17:0] rd_addr;
  logic [15:0] rd_ptr;
  logic [16:0] avail;
  int checks = 0, errors = 0;
  int m_mode = 0, m_rd = 0, m_wl = 0;
  bit m_ovf = 0, m_ev = 0;

  afe_l2_rdaddrgen dut (
    .clk_i(clk), .rst_i(rst), .cfg_startaddr_i(start), .cfg_size_i(size),
    .cfg_datasize_i(ds), .cfg_en_i(en), .cfg_clr_i(clr), .wr_ptr_i(wr_ptr),
    .wr_wrap_i(wrap), .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_gnt_i(gnt),
    .rd_ptr_o(rd_ptr), .bytes_avail_o(avail), .cfg_en_o(cfg_en),
    .overflow_o(ovf), .event_o(ev)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: reader consumed m_rd bytes total, writer completed m_wl laps; lap parity gives the phase.
  function automatic int lap_diff(input int rd, input int wl);
    return (wl - rd / int'(size)) & 1;
  endfunction
  function automatic int m_avail(input int rd, input int wl);
    return (lap_diff(rd, wl) * int'(size) + int'(wr_ptr) - rd % int'(size)) & 'h1ffff;
  endfunction
  function automatic int incr_of(input logic [1:0] d);
    return d == 2'b00 ? 1 : d == 2'b01 ? 2 : 4;
  endfunction

  task automatic model_step();
    int inc, av, nrd, nwl;
    bit g, of;
    inc = incr_of(ds);
    av = m_avail(m_rd, m_wl);
    if (rst || clr) begin
      m_mode <= 0; m_rd <= 0; m_wl <= 0; m_ovf <= 0; m_ev <= 0;
    end else if (m_mode == 0) begin
      m_ev <= 0;
      if (en) begin m_mode <= 1; m_rd <= 0; m_wl <= 0; end
    end else begin
      g = m_mode == 2 && gnt;
      of = (m_mode == 1 || m_mode == 2) && lap_diff(m_rd, m_wl) == 1 && int'(wr_ptr) > m_rd % int'(size);
      nrd = m_rd + (g ? inc : 0);
      nwl = m_wl + (wrap ? 1 : 0);
      m_rd <= nrd;
      m_wl <= nwl;
      m_ev <= g && nrd % int'(size) == 0;
      if (of) m_ovf <= 1;
      m_mode <= of ? 3 : m_mode == 1 ? (av >= inc ? 2 : 1) :
                (g && m_avail(nrd, nwl) < inc) ? 1 : m_mode;
    end
  endtask

  always @(posedge clk) model_step();

  always begin
    @(negedge clk);
    #2;
    chk("rd_req", rd_req, m_mode == 2);
    chk("cfg_en", cfg_en, m_mode == 1 || m_mode == 2);
    chk("rd_addr", rd_addr, (int'(start) + m_rd % int'(size)) & 'h3ffff);
    chk("rd_ptr", rd_ptr, m_rd % int'(size));
    chk("avail", avail, m_avail(m_rd, m_wl));
    chk("overflow", ovf, m_ovf);
    chk("event", ev, m_ev);
  end

  task automatic nxt();
    @(negedge clk);
    #3;
  endtask

  initial begin
    nxt();
    chk("rst_req", rd_req, 0); chk("rst_en", cfg_en, 0); chk("rst_addr", rd_addr, 'h100);
    // basic read
    rst = 0; en = 1; wr_ptr = 8; gnt = 1;
    nxt(); chk("b_en", cfg_en, 1); chk("b_avail", avail, 8);
    en = 0;
    nxt(); chk("b_req0", rd_req, 1); chk("b_addr0", rd_addr, 'h100);
    nxt(); chk("b_addr1", rd_addr, 'h104); chk("b_ptr1", rd_ptr, 4);
    nxt(); chk("b_wait", rd_req, 0); chk("b_avail0", avail, 0); chk("b_ptr2", rd_ptr, 8);
    // held request
    gnt = 0; wr_ptr = 12;
    for (int i = 0; i < 5; i++) begin
      nxt(); chk("h_addr", rd_addr, 'h108); chk("h_ptr", rd_ptr, 8); chk("h_req", rd_req, 1);
    end
    gnt = 1;
    nxt(); chk("h_adv", rd_ptr, 12); chk("h_wait", rd_req, 0);
    gnt = 0; clr = 1;
    // clear priority
    nxt(); clr = 0; en = 1; wr_ptr = 8;
    nxt(); en = 0;
    nxt(); chk("c_req", rd_req, 1);
    clr = 1; en = 1; gnt = 1;
    nxt(); chk("c_ptr", rd_ptr, 0); chk("c_req0", rd_req, 0); chk("c_en0", cfg_en, 0);
    clr = 0; en = 0; gnt = 0;
    // full lap
    size = 8; wr_ptr = 0; en = 1;
    nxt(); en = 0; wrap = 1;
    nxt(); chk("f_avail", avail, 8);
    wrap = 0; gnt = 1;
    nxt(); chk("f_req", rd_req, 1); chk("f_addr", rd_addr, 'h100);
    nxt(); chk("f_ptr4", rd_ptr, 4); chk("f_ev0", ev, 0);
    nxt(); chk("f_ptr0", rd_ptr, 0); chk("f_ev1", ev, 1); chk("f_wait", rd_req, 0);
    nxt(); chk("f_ev_once", ev, 0);
    gnt = 0;
    // simultaneous reader and writer wrap
    wrap = 1;
    nxt(); chk("s_avail", avail, 8);
    wrap = 0; gnt = 1;
    nxt();
    nxt(); chk("s_ptr4", rd_ptr, 4);
    wrap = 1;
    nxt(); chk("s_ptr0", rd_ptr, 0); chk("s_ev", ev, 1); chk("s_avail8", avail, 8);
    chk("s_req", rd_req, 1); chk("s_ovf", ovf, 0);
    wrap = 0; gnt = 0; clr = 1;
    // overflow
    nxt(); clr = 0; en = 1; wr_ptr = 0;
    nxt(); en = 0; wrap = 1;
    nxt(); wrap = 0;
    nxt(); chk("o_req", rd_req, 1);
    wr_ptr = 4; gnt = 1;
    nxt(); chk("o_flag", ovf, 1); chk("o_req0", rd_req, 0); chk("o_ptr", rd_ptr, 4); chk("o_en", cfg_en, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); chk("o_stay", ovf, 1); chk("o_ptr_hold", rd_ptr, 4);
    end
    gnt = 0; clr = 1;
    nxt(); chk("o_clr", ovf, 0); chk("o_idle", cfg_en, 0);
    // reset mid-request
    clr = 0; en = 1; wr_ptr = 4;
    nxt(); en = 0;
    nxt(); chk("r_req", rd_req, 1);
    rst = 1; gnt = 1;
    nxt(); chk("r_req0", rd_req, 0); chk("r_en0", cfg_en, 0); chk("r_ptr", rd_ptr, 0);
    rst = 0; gnt = 0;
    nxt(); chk("r_idle", rd_req, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
